// File: rtl/vpu_seq_pkg.sv
// Shared state encoding and default parameter values for the VPU stage sequencer.
package vpu_seq_pkg;

    localparam int          DEF_POWER_WIDTH    = 4;
    localparam int          DEF_TO_WIDTH       = 16;
    localparam int unsigned DEF_TIMEOUT_CYCLES = 32'h0000_FFFF;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        ST_ADDX  = 3'd1,
        WT_ADDX  = 3'd2,
        ST_MONOX = 3'd3,
        WT_MONOX = 3'd4,
        FIN      = 3'd5
    } seq_state_e;

endpackage

// File: rtl/vpu_seq_watchdog.sv
// Per-stage wait counter for the sequencer, only built when VPU_SEQ_WATCHDOG_EN is defined.
// timeout_o fires in the cycle the count reaches TIMEOUT_CYCLES while counting is enabled.
module vpu_seq_watchdog #(
    parameter int          TO_WIDTH       = 16,
    parameter int unsigned TIMEOUT_CYCLES = 32'h0000_FFFF
) (
    input  logic clk,
    input  logic rst,
    input  logic clear_i,
    input  logic cnt_en_i,
    output logic timeout_o
);

    localparam logic [TO_WIDTH-1:0] LAST_CNT = TO_WIDTH'(TIMEOUT_CYCLES - 1);

    logic [TO_WIDTH-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (cnt_en_i) begin
            cnt_d = cnt_q + TO_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign timeout_o = cnt_en_i && (cnt_q == LAST_CNT);

endmodule

// File: rtl/vpu_stage_sequencer.sv
// Two-stage (addx then monox) job sequencer; optional stage watchdog under VPU_SEQ_WATCHDOG_EN.
// state | meaning: IDLE wait job | ST_* pulse stage start | WT_* wait stage done | FIN job end pulse
module vpu_stage_sequencer
    import vpu_seq_pkg::*;
#(
    parameter int          POWER_WIDTH    = DEF_POWER_WIDTH,
    parameter int          TO_WIDTH       = DEF_TO_WIDTH,
    parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_req_valid,
    output logic                   o_req_ready,
    input  logic [POWER_WIDTH-1:0] i_n_addx,
    input  logic [POWER_WIDTH-1:0] i_n_monox,
    input  logic                   i_mode,
    input  logic                   i_s7_mode,
    input  logic                   i_trace,
    input  logic                   i_abort,
    output logic                   o_en,
    output logic                   o_start_addx,
    output logic                   o_start_monox,
    input  logic                   i_done_addx,
    input  logic                   i_done_monox,
    output logic [POWER_WIDTH-1:0] o_n_addx,
    output logic [POWER_WIDTH-1:0] o_n_monox,
    output logic                   o_mode,
    output logic                   o_s7_mode,
    output logic                   o_is_trace,
    output logic                   o_busy,
    output logic                   o_job_done,
    output logic                   o_err
);

    seq_state_e             state_q, state_d;
    logic                   err_q, err_set;
    logic                   accept, timeout;
    logic [POWER_WIDTH-1:0] n_addx_q, n_monox_q;
    logic                   mode_q, s7_mode_q, trace_q;

    assign accept = (state_q == IDLE) && i_req_valid;

`ifdef VPU_SEQ_WATCHDOG_EN
    vpu_seq_watchdog #(
        .TO_WIDTH       (TO_WIDTH),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk       (clk),
        .rst       (rst),
        .clear_i   ((state_q == ST_ADDX) || (state_q == ST_MONOX)),
        .cnt_en_i  ((state_q == WT_ADDX) || (state_q == WT_MONOX)),
        .timeout_o (timeout)
    );
`else
    logic unused_cfg;
    assign unused_cfg = ^TO_WIDTH'(TIMEOUT_CYCLES);
    assign timeout    = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        err_set = 1'b0;
        case (state_q)
            IDLE:     if (i_req_valid) state_d = ST_ADDX;
            ST_ADDX:  state_d = WT_ADDX;
            WT_ADDX: begin
                if (i_done_addx) begin
                    state_d = ST_MONOX;
                end else if (timeout) begin
                    state_d = FIN;
                    err_set = 1'b1;
                end
            end
            ST_MONOX: state_d = WT_MONOX;
            WT_MONOX: begin
                if (i_done_monox) begin
                    state_d = FIN;
                end else if (timeout) begin
                    state_d = FIN;
                    err_set = 1'b1;
                end
            end
            FIN:      state_d = IDLE;
            default:  state_d = IDLE;
        endcase
        // Abort overrides any done pulse; an abort during FIN only flags the error.
        if (i_abort && (state_q != IDLE)) begin
            err_set = 1'b1;
            state_d = (state_q == FIN) ? IDLE : FIN;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            err_q     <= 1'b0;
            n_addx_q  <= '0;
            n_monox_q <= '0;
            mode_q    <= 1'b0;
            s7_mode_q <= 1'b0;
            trace_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                err_q     <= 1'b0;
                n_addx_q  <= i_n_addx;
                n_monox_q <= i_n_monox;
                mode_q    <= i_mode;
                s7_mode_q <= i_s7_mode;
                trace_q   <= i_trace;
            end else if (err_set) begin
                err_q <= 1'b1;
            end
        end
    end

    assign o_req_ready   = (state_q == IDLE);
    assign o_busy        = (state_q != IDLE);
    assign o_en          = (state_q == ST_ADDX) || (state_q == WT_ADDX) ||
                           (state_q == ST_MONOX) || (state_q == WT_MONOX);
    assign o_start_addx  = (state_q == ST_ADDX);
    assign o_start_monox = (state_q == ST_MONOX);
    assign o_job_done    = (state_q == FIN);
    assign o_err         = err_q;
    assign o_n_addx      = n_addx_q;
    assign o_n_monox     = n_monox_q;
    assign o_mode        = mode_q;
    assign o_s7_mode     = s7_mode_q;
    assign o_is_trace    = trace_q;

endmodule

// File: tb/tb_vpu_stage_sequencer.sv
// Self-checking bench for vpu_stage_sequencer: job table with a scoreboard plus hand-written
// reset, mid-job reset and back-to-back sequences.
module tb_vpu_stage_sequencer;

    localparam int PW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_req_valid, o_req_ready;
    logic [PW-1:0] i_n_addx, i_n_monox;
    logic          i_mode, i_s7_mode, i_trace, i_abort;
    logic          o_en, o_start_addx, o_start_monox;
    logic          i_done_addx, i_done_monox;
    logic [PW-1:0] o_n_addx, o_n_monox;
    logic          o_mode, o_s7_mode, o_is_trace;
    logic          o_busy, o_job_done, o_err;

    always #5 clk = ~clk;

    vpu_stage_sequencer #(
        .POWER_WIDTH    (PW),
        .TO_WIDTH       (16),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .i_req_valid   (i_req_valid),
        .o_req_ready   (o_req_ready),
        .i_n_addx      (i_n_addx),
        .i_n_monox     (i_n_monox),
        .i_mode        (i_mode),
        .i_s7_mode     (i_s7_mode),
        .i_trace       (i_trace),
        .i_abort       (i_abort),
        .o_en          (o_en),
        .o_start_addx  (o_start_addx),
        .o_start_monox (o_start_monox),
        .i_done_addx   (i_done_addx),
        .i_done_monox  (i_done_monox),
        .o_n_addx      (o_n_addx),
        .o_n_monox     (o_n_monox),
        .o_mode        (o_mode),
        .o_s7_mode     (o_s7_mode),
        .o_is_trace    (o_is_trace),
        .o_busy        (o_busy),
        .o_job_done    (o_job_done),
        .o_err         (o_err)
    );

    // ad/md: cycles from start pulse to done pulse; abort_at/spur_at: job cycle index, -1 = never
    typedef struct {
        logic [PW-1:0] n_addx;
        logic [PW-1:0] n_monox;
        logic [2:0]    modes;
        int            ad;
        int            md;
        int            abort_at;
        int            spur_at;
        logic          exp_err;
        int            exp_lat;
        int            exp_sm;
    } vec_t;

    typedef struct {
        logic [PW-1:0] n_addx;
        logic [PW-1:0] n_monox;
        logic [2:0]    modes;
        logic          err;
        int            lat;
        int            sm;
    } exp_t;

    localparam int NVEC = 8;
    vec_t vecs [NVEC];
    exp_t sb_q [$];
    int   errors = 0;
    int   checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic clear_inputs();
        i_req_valid  = 1'b0;
        i_abort      = 1'b0;
        i_done_addx  = 1'b0;
        i_done_monox = 1'b0;
    endtask

    task automatic wait_ready(input string name);
        int n;
        n = 0;
        while (!o_req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!o_req_ready) check(name, 32'(o_req_ready), 32'd1);
    endtask

    task automatic run_job(input vec_t v, input int idx);
        exp_t          e;
        int            sa_cnt, sm_cnt, sm_t, done_t, en_bad;
        logic [PW-1:0] g_addx, g_monox;
        logic [2:0]    g_modes;
        logic          g_err, g_ready;
        wait_ready($sformatf("job%0d_ready_wait", idx));
        i_req_valid = 1'b1;
        i_n_addx    = v.n_addx;
        i_n_monox   = v.n_monox;
        {i_mode, i_s7_mode, i_trace} = v.modes;
        @(posedge clk);
        e.n_addx  = v.n_addx;
        e.n_monox = v.n_monox;
        e.modes   = v.modes;
        e.err     = v.exp_err;
        e.lat     = v.exp_lat;
        e.sm      = v.exp_sm;
        sb_q.push_back(e);
        sa_cnt = 0; sm_cnt = 0; sm_t = -1; done_t = -1; en_bad = 0;
        g_addx = '0; g_monox = '0; g_modes = '0; g_err = 1'b0; g_ready = 1'b1;
        for (int t = 0; t < 300 && done_t < 0; t++) begin
            @(negedge clk);
            i_req_valid = 1'b0;
            if (o_start_addx) sa_cnt++;
            if (o_start_monox) begin
                sm_cnt++;
                sm_t = t;
            end
            if (o_job_done) begin
                done_t  = t;
                g_addx  = o_n_addx;
                g_monox = o_n_monox;
                g_modes = {o_mode, o_s7_mode, o_is_trace};
                g_err   = o_err;
                g_ready = o_req_ready;
                en_bad += int'(o_en) + int'(!o_busy);
                clear_inputs();
            end else begin
                en_bad      += int'(!o_en) + int'(!o_busy);
                i_done_addx  = (t == v.ad);
                i_done_monox = ((sm_t >= 0) && (t == sm_t + v.md)) || (t == v.spur_at);
                i_abort      = (t == v.abort_at);
            end
        end
        clear_inputs();
        check($sformatf("job%0d_done_seen", idx), 32'(done_t >= 0), 32'd1);
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check($sformatf("job%0d_latency", idx), done_t, e.lat);
            check($sformatf("job%0d_err", idx), 32'(g_err), 32'(e.err));
            check($sformatf("job%0d_n_addx", idx), 32'(g_addx), 32'(e.n_addx));
            check($sformatf("job%0d_n_monox", idx), 32'(g_monox), 32'(e.n_monox));
            check($sformatf("job%0d_modes", idx), 32'(g_modes), 32'(e.modes));
            check($sformatf("job%0d_start_addx_cnt", idx), sa_cnt, 1);
            check($sformatf("job%0d_start_monox_cnt", idx), sm_cnt, e.sm);
            check($sformatf("job%0d_en_busy_bad", idx), en_bad, 0);
            check($sformatf("job%0d_ready_in_fin", idx), 32'(g_ready), 32'd0);
        end
    endtask

    initial begin
        int f;
        int jd;
        //           n_addx n_monox modes   ad    md  abort spur  err lat sm
`ifdef VPU_SEQ_WATCHDOG_EN
        vecs[0] = '{4'd4,  4'd5,  3'b101,  10,   20,  -1,  -1, 1'b1,  9, 0};
        vecs[7] = '{4'd8,  4'd8,  3'b010, 1000,   1,  -1,  -1, 1'b1,  9, 0};
`else
        vecs[0] = '{4'd4,  4'd5,  3'b101,  10,   20,  -1,  -1, 1'b0, 32, 1};
        vecs[7] = '{4'd8,  4'd8,  3'b010, 1000,   1, 100,  -1, 1'b1, 101, 0};
`endif
        vecs[1] = '{4'd15, 4'd0,  3'b010,   1,    1,  -1,  -1, 1'b0,  4, 1};
        vecs[2] = '{4'd7,  4'd3,  3'b111,   3,    2,   3,  -1, 1'b1,  4, 0};
        vecs[3] = '{4'd2,  4'd9,  3'b000,   2,    6,   5,  -1, 1'b1,  6, 1};
        vecs[4] = '{4'd1,  4'd1,  3'b100,   5,    4,   0,  -1, 1'b1,  1, 0};
        vecs[5] = '{4'd6,  4'd12, 3'b001,   2,    2,  -1,  -1, 1'b0,  6, 1};
        vecs[6] = '{4'd3,  4'd4,  3'b110,   3,    4,  -1,   1, 1'b0,  9, 1};

        rst = 1'b1;
        clear_inputs();
        i_n_addx = '0; i_n_monox = '0;
        i_mode = 1'b0; i_s7_mode = 1'b0; i_trace = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_ready", 32'(o_req_ready), 32'd1);
        check("rst_ctl_outs", 32'({o_busy, o_en, o_start_addx, o_start_monox, o_job_done, o_err}), 32'd0);
        check("rst_fields", 32'({o_n_addx, o_n_monox, o_mode, o_s7_mode, o_is_trace}), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_abort_ignored_pre", 32'(o_busy), 32'd0);
        i_abort = 1'b1;
        @(negedge clk);
        i_abort = 1'b0;
        check("idle_abort_ignored", 32'({o_busy, o_err}), 32'd0);

        for (int i = 0; i < NVEC; i++) run_job(vecs[i], i);

        // Reset while waiting on monox: drop straight to IDLE, no job_done afterwards.
        wait_ready("rstjob_ready_wait");
        i_req_valid = 1'b1; i_n_addx = 4'd6; i_n_monox = 4'd7;
        {i_mode, i_s7_mode, i_trace} = 3'b111;
        @(posedge clk);
        f = -1;
        for (int t = 0; t < 20 && f < 0; t++) begin
            @(negedge clk);
            i_req_valid = 1'b0;
            if (o_start_monox) f = t;
            i_done_addx = (t == 1);
        end
        i_done_addx = 1'b0;
        repeat (3) @(negedge clk);
        check("rstjob_in_wait_monox", 32'({o_busy, o_en}), 32'b11);
        check("rstjob_pre_fields", 32'({o_n_addx, o_n_monox}), 32'({4'd6, 4'd7}));
        rst = 1'b1;
        @(negedge clk);
        check("rstjob_ctl_outs", 32'({o_busy, o_en, o_start_addx, o_start_monox, o_job_done, o_err}), 32'd0);
        check("rstjob_fields", 32'({o_n_addx, o_n_monox, o_mode, o_s7_mode, o_is_trace}), 32'd0);
        check("rstjob_ready", 32'(o_req_ready), 32'd1);
        rst = 1'b0;
        jd = 0;
        for (int t = 0; t < 6; t++) begin
            @(negedge clk);
            i_done_monox = (t == 0);
            jd += int'(o_job_done) + int'(o_busy);
        end
        i_done_monox = 1'b0;
        check("rstjob_no_job_done", jd, 0);

        // Request held high across FIN: second job accepted the cycle after FIN, err cleared.
        wait_ready("b2b_ready_wait");
        i_req_valid = 1'b1; i_n_addx = 4'd3; i_n_monox = 4'd3;
        {i_mode, i_s7_mode, i_trace} = 3'b000;
        @(posedge clk);
        f = -1;
        for (int t = 0; t < 40 && f < 0; t++) begin
            @(negedge clk);
            i_abort = (t == 2);
            if (o_job_done) begin
                f = t;
                i_abort = 1'b0;
                check("b2b_fin_ready", 32'(o_req_ready), 32'd0);
                i_n_addx = 4'd9; i_n_monox = 4'd10;
                {i_mode, i_s7_mode, i_trace} = 3'b011;
            end
        end
        i_abort = 1'b0;
        check("b2b_first_fin_cycle", f, 3);
        @(negedge clk);
        check("b2b_idle_ready", 32'(o_req_ready), 32'd1);
        check("b2b_err_held", 32'(o_err), 32'd1);
        @(negedge clk);
        check("b2b_start_addx", 32'(o_start_addx), 32'd1);
        check("b2b_err_cleared", 32'(o_err), 32'd0);
        check("b2b_fields", 32'({o_n_addx, o_n_monox, o_mode, o_s7_mode, o_is_trace}),
              32'({4'd9, 4'd10, 3'b011}));
        i_req_valid = 1'b0;
        i_abort = 1'b1;
        @(negedge clk);
        i_abort = 1'b0;
        check("b2b_abort_fin", 32'({o_job_done, o_err}), 32'b11);
        @(negedge clk);
        check("b2b_back_idle", 32'({o_busy, o_req_ready}), 32'b01);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
